// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: instruction field positions, lwn/swn
// encodings, IF/ID stage states and the decoded-field payload.
package mips_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned OPC_W     = 6;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned IMM_W     = 16;

  localparam int unsigned OPC_MSB   = 31;
  localparam int unsigned OPC_LSB   = 26;
  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_MSB = 10;
  localparam int unsigned SHAMT_LSB = 6;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned IMM_MSB   = 15;
  localparam int unsigned IMM_LSB   = 0;
  localparam int unsigned JIDX_MSB  = 25;
  localparam int unsigned JIDX_LSB  = 0;
  localparam int unsigned JPAGE_LSB = 28;

  localparam logic [OPC_W-1:0]   OPC_NMEM  = 6'b000001;
  localparam logic [FUNCT_W-1:0] FUNCT_LWN = 6'b100001;
  localparam logic [FUNCT_W-1:0] FUNCT_SWN = 6'b010011;

  // Enumerators carry a prefix so they never collide with the SKID parameter.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  typedef struct packed {
    logic [OPC_W-1:0]   opcode;
    logic [FUNCT_W-1:0] funct;
    logic [REG_W-1:0]   rd_addr1;
    logic [REG_W-1:0]   rd_addr2;
    logic [IMM_W-1:0]   imm;
    logic [REG_W-1:0]   shamt;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic               is_nmem;
  } id_fields_t;

  function automatic logic is_nmem_op(input logic [OPC_W-1:0] opcode,
                                      input logic [FUNCT_W-1:0] funct);
    return (opcode == OPC_NMEM) && ((funct == FUNCT_LWN) || (funct == FUNCT_SWN));
  endfunction

endpackage

// File: rtl/if_id_field_decode.sv
// Purely combinational decode of a stored instruction and its PC+4 into the
// fields consumed by the ID stage; shared with hazard/forwarding logic.
module if_id_field_decode
  import mips_pkg::*;
#(
  parameter int unsigned PC_W       = 32,
  parameter bit          EXT_DECODE = 1'b1
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [PC_W-1:0]    pc4,
  output id_fields_t         fields,
  output logic [PC_W-1:0]    jump_addr
);

  always_comb begin
    fields          = '0;
    fields.opcode   = instr[OPC_MSB:OPC_LSB];
    fields.funct    = instr[FUNCT_MSB:FUNCT_LSB];
    fields.rs       = instr[RS_MSB:RS_LSB];
    fields.rt       = instr[RT_MSB:RT_LSB];
    fields.rd       = instr[RD_MSB:RD_LSB];
    fields.shamt    = instr[SHAMT_MSB:SHAMT_LSB];
    fields.imm      = instr[IMM_MSB:IMM_LSB];
    fields.rd_addr1 = instr[RS_MSB:RS_LSB];
    fields.is_nmem  = EXT_DECODE && is_nmem_op(instr[OPC_MSB:OPC_LSB], instr[FUNCT_MSB:FUNCT_LSB]);
    // lwn/swn read their second operand from the rd field
    fields.rd_addr2 = fields.is_nmem ? instr[RD_MSB:RD_LSB] : instr[RT_MSB:RT_LSB];
  end

  if (PC_W > JPAGE_LSB) begin : g_page
    assign jump_addr = {pc4[PC_W-1:JPAGE_LSB], instr[JIDX_MSB:JIDX_LSB], 2'b00};
    logic unused_pc4_low;
    assign unused_pc4_low = ^pc4[JPAGE_LSB-1:0];
  end else begin : g_nopage
    assign jump_addr = PC_W'({instr[JIDX_MSB:JIDX_LSB], 2'b00});
    logic unused_pc4;
    assign unused_pc4 = ^pc4;
  end

endmodule

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline stage with valid/ready handshake, synchronous flush and an
// optional 2-entry skid buffer; outputs decode from the main entry only.
module if_id_stage_reg
  import mips_pkg::*;
#(
  parameter int unsigned PC_W       = 32,
  parameter bit          SKID       = 1'b1,
  parameter bit          EXT_DECODE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc4,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [FUNCT_W-1:0] out_funct,
  output logic [PC_W-1:0]    out_pc4,
  output logic [PC_W-1:0]    out_jump_addr,
  output logic [REG_W-1:0]   out_rd_addr1,
  output logic [REG_W-1:0]   out_rd_addr2,
  output logic [IMM_W-1:0]   out_imm,
  output logic [REG_W-1:0]   out_shamt,
  output logic [REG_W-1:0]   out_rs,
  output logic [REG_W-1:0]   out_rt,
  output logic [REG_W-1:0]   out_rd,
  output logic               out_is_nmem
);

  state_t             state, state_nxt;
  logic [INSTR_W-1:0] main_instr, skid_instr;
  logic [PC_W-1:0]    main_pc4, skid_pc4;
  logic               load_main_in, load_main_skid, load_skid;
  id_fields_t         fields;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_valid) begin
          state_nxt    = ST_FULL;
          load_main_in = 1'b1;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          if (in_valid) load_main_in = 1'b1;
          else          state_nxt    = ST_EMPTY;
        end else if (in_valid && SKID) begin
          state_nxt = ST_SKID;
          load_skid = 1'b1;
        end
      end
      ST_SKID: begin
        if (out_ready) begin
          state_nxt      = ST_FULL;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // flush discards the handshaking beat and any skid beat; payloads just hold
    if (flush) begin
      state_nxt      = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_instr <= '0;
      main_pc4   <= '0;
      skid_instr <= '0;
      skid_pc4   <= '0;
    end else begin
      if (load_main_in) begin
        main_instr <= in_instr;
        main_pc4   <= in_pc4;
      end else if (load_main_skid) begin
        main_instr <= skid_instr;
        main_pc4   <= skid_pc4;
      end
      if (load_skid) begin
        skid_instr <= in_instr;
        skid_pc4   <= in_pc4;
      end
    end
  end

  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = SKID ? (state != ST_SKID) : (!out_valid || out_ready);

  if_id_field_decode #(
    .PC_W       (PC_W),
    .EXT_DECODE (EXT_DECODE)
  ) u_decode (
    .instr     (main_instr),
    .pc4       (main_pc4),
    .fields    (fields),
    .jump_addr (out_jump_addr)
  );

  assign out_pc4      = main_pc4;
  assign out_opcode   = fields.opcode;
  assign out_funct    = fields.funct;
  assign out_rd_addr1 = fields.rd_addr1;
  assign out_rd_addr2 = fields.rd_addr2;
  assign out_imm      = fields.imm;
  assign out_shamt    = fields.shamt;
  assign out_rs       = fields.rs;
  assign out_rt       = fields.rt;
  assign out_rd       = fields.rd;
  assign out_is_nmem  = fields.is_nmem;

endmodule
